// File: rtl/key_pkg.sv
// Shared definitions for the emulated key-press generator.
// Holds the FSM state encoding, the default timing parameters (125 MHz clock)
// and the debounce delay the generated presses must outlast.
package key_pkg;

    // Press sequencing states
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_BOUNCE_IN  = 3'd1,
        ST_HOLD       = 3'd2,
        ST_BOUNCE_OUT = 3'd3,
        ST_GAP        = 3'd4
    } key_state_e;

    // 40 ms key debounce at 125 MHz
    localparam logic [31:0] DEBOUNCE_DLY   = 32'd5000000;

    // Defaults: press and gap just exceed the debounce delay
    localparam logic [31:0] DEF_HOLD_MIN   = 32'd5000001;
    localparam logic [31:0] DEF_GAP        = 32'd5000001;
    localparam logic [31:0] DEF_BOUNCE_CNT = 32'd4;
    localparam logic [31:0] DEF_BOUNCE_PER = 32'd12500;

    // Effective press length: the request, but never shorter than the minimum
    function automatic logic [31:0] clamp_hold(input logic [31:0] hold_val,
                                               input logic [31:0] hold_min);
        logic [31:0] res;
        if (hold_val < hold_min) begin
            res = hold_min;
        end else begin
            res = hold_val;
        end
        return res;
    endfunction

endpackage

// File: rtl/key_tick_cnt.sv
// Loadable 32-bit down-counter with a zero flag; times bounce segments,
// the press hold and the post-press gap.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset (count clears to 0)
//   load_i         load load_val_i this cycle (has priority over dec_i)
//   dec_i          decrement by one; saturates at zero
//   load_val_i     value to load
//   zero_o         count is zero
module key_tick_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        dec_i,
    input  logic [31:0] load_val_i,
    output logic        zero_o
);

    logic [31:0] cnt_q;

    // Count register: load has priority, decrement stops at zero so it never wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 32'd0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != 32'd0)) begin
            cnt_q <= cnt_q - 32'd1;
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign zero_o = (cnt_q == 32'd0);

endmodule

// File: rtl/key_press_gen.sv
// Emulated push-button: on request, drives an active-low key line through a
// bouncy press, a clean hold, a bouncy release and a quiet gap, then pulses done.
// Ports:
//   clk    sole clock
//   rst_n  asynchronous active-low reset; releases the key line at once
//   req    press request, only sampled while idle
//   hold   requested press length in cycles, latched with req
//   busy   high from the cycle after acceptance until done
//   done   one-cycle pulse after the gap ends
//   kout   key line, 0 = pressed, idles at 1
module key_press_gen
    import key_pkg::*;
#(
    parameter logic [31:0] HOLD_MIN   = DEF_HOLD_MIN,
    parameter logic [31:0] GAP        = DEF_GAP,
    parameter logic [31:0] BOUNCE_CNT = DEF_BOUNCE_CNT,
    parameter logic [31:0] BOUNCE_PER = DEF_BOUNCE_PER
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [31:0] hold,
    output logic        busy,
    output logic        done,
    output logic        kout
);

    localparam bit          HAS_BOUNCE = (BOUNCE_CNT != 32'd0);
    // A bounce phase has 2*BOUNCE_CNT-1 levels; this is the number still to
    // come after the first one.
    localparam logic [31:0] SEG_LAST   = HAS_BOUNCE ? ((BOUNCE_CNT << 1) - 32'd2) : 32'd0;
    // The counter runs N-1 .. 0, so a phase of N cycles loads N-1
    localparam logic [31:0] PER_LD     = BOUNCE_PER - 32'd1;
    localparam logic [31:0] GAP_LD     = GAP - 32'd1;

    key_state_e  state_q;
    logic [31:0] hold_eff_q;
    logic [31:0] seg_q;
    logic        kout_q;
    logic        busy_q;
    logic        done_q;

    logic [31:0] hold_eff_s;
    logic        cnt_load_d;
    logic        cnt_dec_d;
    logic [31:0] cnt_val_d;
    logic        cnt_zero_s;

    assign hold_eff_s = clamp_hold(hold, HOLD_MIN);

    key_tick_cnt u_tick (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load_d),
        .dec_i      (cnt_dec_d),
        .load_val_i (cnt_val_d),
        .zero_o     (cnt_zero_s)
    );

    // Timer control: reload with the length of the phase being entered, else count down
    always_comb begin
        cnt_load_d = 1'b0;
        cnt_dec_d  = 1'b0;
        cnt_val_d  = 32'd0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    cnt_load_d = 1'b1;
                    cnt_val_d  = HAS_BOUNCE ? PER_LD : (hold_eff_s - 32'd1);
                end else begin
                    cnt_load_d = 1'b0;
                end
            end
            ST_BOUNCE_IN: begin
                if (cnt_zero_s) begin
                    cnt_load_d = 1'b1;
                    cnt_val_d  = (seg_q == 32'd0) ? (hold_eff_q - 32'd1) : PER_LD;
                end else begin
                    cnt_dec_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_zero_s) begin
                    cnt_load_d = 1'b1;
                    cnt_val_d  = HAS_BOUNCE ? PER_LD : GAP_LD;
                end else begin
                    cnt_dec_d = 1'b1;
                end
            end
            ST_BOUNCE_OUT: begin
                if (cnt_zero_s) begin
                    cnt_load_d = 1'b1;
                    cnt_val_d  = (seg_q == 32'd0) ? GAP_LD : PER_LD;
                end else begin
                    cnt_dec_d = 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_zero_s) begin
                    cnt_dec_d = 1'b0;
                end else begin
                    cnt_dec_d = 1'b1;
                end
            end
            default: begin
                cnt_load_d = 1'b0;
                cnt_dec_d  = 1'b0;
            end
        endcase
    end

    // Press sequencer with registered key line, busy and done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            hold_eff_q <= 32'd0;
            seg_q      <= 32'd0;
            kout_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        hold_eff_q <= hold_eff_s;
                        seg_q      <= SEG_LAST;
                        kout_q     <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= HAS_BOUNCE ? ST_BOUNCE_IN : ST_HOLD;
                    end
                end
                ST_BOUNCE_IN: begin
                    if (cnt_zero_s) begin
                        if (seg_q == 32'd0) begin
                            // last bounce level is already low; hold continues it
                            kout_q  <= 1'b0;
                            state_q <= ST_HOLD;
                        end else begin
                            seg_q  <= seg_q - 32'd1;
                            kout_q <= ~kout_q;
                        end
                    end
                end
                ST_HOLD: begin
                    if (cnt_zero_s) begin
                        kout_q <= 1'b1;
                        seg_q  <= SEG_LAST;
                        state_q <= HAS_BOUNCE ? ST_BOUNCE_OUT : ST_GAP;
                    end
                end
                ST_BOUNCE_OUT: begin
                    if (cnt_zero_s) begin
                        if (seg_q == 32'd0) begin
                            kout_q  <= 1'b1;
                            state_q <= ST_GAP;
                        end else begin
                            seg_q  <= seg_q - 32'd1;
                            kout_q <= ~kout_q;
                        end
                    end
                end
                ST_GAP: begin
                    if (cnt_zero_s) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    kout_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign kout = kout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
